jelly_ddr_sdram_dq_sched: RTL and testbench



---
 rtl/jelly_ddr_sdram_pkg.sv | 32 +++
 rtl/jelly_ddr_sdram_slot_shift.sv | 51 +++++
 rtl/jelly_ddr_sdram_dq_sched.sv | 177 +++++++++++++++++
 tb/tb_jelly_ddr_sdram_dq_sched.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jelly_ddr_sdram_pkg.sv
// Shared helpers for the DDR-SDRAM data-path scheduler: slot direction tags,
// burst/horizon arithmetic and parameter legality checks.
package jelly_ddr_sdram_pkg;

  localparam logic [1:0] DIR_NONE  = 2'd0;
  localparam logic [1:0] DIR_WRITE = 2'd1;
  localparam logic [1:0] DIR_READ  = 2'd2;

  function automatic int unsigned burst_cycles(int unsigned burst_length);
    return burst_length / 2;
  endfunction

  // Deep enough to hold the furthest insertion plus one guard slot.
  function automatic int unsigned slot_horizon(int unsigned cas_latency,
                                               int unsigned read_capture_delay,
                                               int unsigned write_latency,
                                               int unsigned burst_length);
    int unsigned lat;
    lat = (cas_latency + read_capture_delay > write_latency) ?
          cas_latency + read_capture_delay : write_latency;
    return lat + burst_cycles(burst_length) + 1;
  endfunction

  function automatic bit burst_length_legal(int unsigned burst_length);
    return (burst_length == 2) || (burst_length == 4) || (burst_length == 8);
  endfunction

  function automatic bit cas_latency_legal(int unsigned cas_latency);
    return (cas_latency >= 2) && (cas_latency <= 3);
  endfunction

endpackage

// File: rtl/jelly_ddr_sdram_slot_shift.sv
// Shift register of bus-slot direction tags; entry 0 is the current cycle's slot.
// Insert vectors address slots relative to the next cycle (bit i = slot now+1+i).
module jelly_ddr_sdram_slot_shift
  import jelly_ddr_sdram_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] ins_write,
  input  logic [DEPTH-1:0] ins_read,
  input  logic [DEPTH-1:0] ins_last,
  output logic [DEPTH-1:0] occ_write,
  output logic [DEPTH-1:0] occ_read,
  output logic             head_last
);

  logic [1:0] tag_q [DEPTH];
  logic [1:0] tag_d [DEPTH];
  logic [DEPTH-1:0] last_q;
  logic [DEPTH-1:0] last_d;

  // Accepted commands never overlap, so an insert simply replaces the shifted-in tag.
  always_comb begin
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      tag_d[i]  = ins_write[i] ? DIR_WRITE : ins_read[i] ? DIR_READ : tag_q[i+1];
      last_d[i] = (ins_write[i] | ins_read[i]) ? ins_last[i] : last_q[i+1];
    end
    tag_d[DEPTH-1]  = ins_write[DEPTH-1] ? DIR_WRITE : ins_read[DEPTH-1] ? DIR_READ : DIR_NONE;
    last_d[DEPTH-1] = ins_last[DEPTH-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q  <= '{default: DIR_NONE};
      last_q <= '0;
    end else begin
      tag_q  <= tag_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_write[i] = (tag_q[i] == DIR_WRITE);
      occ_read[i]  = (tag_q[i] == DIR_READ);
    end
    head_last = last_q[0];
  end

endmodule

// File: rtl/jelly_ddr_sdram_dq_sched.sv
// DDR-SDRAM DQ/DQS scheduler: turns read/write strobes into drive/valid windows.
// Define JELLY_DDR_SDRAM_DQ_SCHED_STAT_EN to enable the accepted-burst counters.
module jelly_ddr_sdram_dq_sched
  import jelly_ddr_sdram_pkg::*;
#(
  parameter int unsigned SDRAM_DQ_WIDTH     = 16,
  parameter int unsigned SDRAM_DM_WIDTH     = SDRAM_DQ_WIDTH / 8,
  parameter int unsigned BURST_LENGTH       = 4,
  parameter int unsigned CAS_LATENCY        = 2,
  parameter int unsigned WRITE_LATENCY      = 1,
  parameter int unsigned READ_CAPTURE_DELAY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_write,
  input  logic                      cmd_read,
  input  logic [SDRAM_DQ_WIDTH-1:0] s_wdata_even,
  input  logic [SDRAM_DQ_WIDTH-1:0] s_wdata_odd,
  input  logic [SDRAM_DM_WIDTH-1:0] s_wmask_even,
  input  logic [SDRAM_DM_WIDTH-1:0] s_wmask_odd,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [SDRAM_DQ_WIDTH-1:0] m_rdata_even,
  output logic [SDRAM_DQ_WIDTH-1:0] m_rdata_odd,
  output logic                      m_rvalid,
  output logic                      m_rlast,
  output logic                      dq_write_next_en,
  output logic                      dqs_write_next_en,
  output logic [SDRAM_DQ_WIDTH-1:0] dq_write_even,
  output logic [SDRAM_DQ_WIDTH-1:0] dq_write_odd,
  output logic [SDRAM_DM_WIDTH-1:0] dm_write_even,
  output logic [SDRAM_DM_WIDTH-1:0] dm_write_odd,
  input  logic [SDRAM_DQ_WIDTH-1:0] dq_read_even,
  input  logic [SDRAM_DQ_WIDTH-1:0] dq_read_odd,
  output logic                      busy,
  output logic                      err_underrun,
  output logic                      err_conflict,
  output logic [15:0]               stat_write_bursts,
  output logic [15:0]               stat_read_bursts
);

  localparam int BC    = int'(burst_cycles(BURST_LENGTH));
  localparam int CL    = int'(CAS_LATENCY);
  localparam int WL    = int'(WRITE_LATENCY);
  localparam int RCD   = int'(READ_CAPTURE_DELAY);
  localparam int DEPTH = int'(slot_horizon(CAS_LATENCY, READ_CAPTURE_DELAY,
                                           WRITE_LATENCY, BURST_LENGTH));

  param_legal: assert property (@(posedge clk)
    burst_length_legal(BURST_LENGTH) && cas_latency_legal(CAS_LATENCY) &&
    (WRITE_LATENCY >= 1) && (READ_CAPTURE_DELAY <= 2))
    else $error("jelly_ddr_sdram_dq_sched: illegal parameter set");

  logic [DEPTH-1:0] win_w, win_r;
  logic [DEPTH-1:0] occ_write, occ_read, occ_any;
  logic [DEPTH-1:0] ins_write, ins_read, ins_last;
  logic             head_last;
  logic             wr_hit, rd_hit;
  logic             accept_write, accept_read, conflict;

  assign occ_any = occ_write | occ_read;

  always_comb begin
    win_w     = '0;
    win_r     = '0;
    ins_write = '0;
    ins_read  = '0;
    ins_last  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      win_w[i] = (i >= WL) && (i < WL + BC);
      win_r[i] = (i >= CL) && (i < CL + BC);
    end
    // The slot just before the window must not carry the opposite direction.
    wr_hit = (|(win_w & occ_any)) | occ_read[WL-1];
    rd_hit = (|(win_r & occ_any)) | occ_write[CL-1];
    accept_write = cmd_write & ~reset & ~wr_hit;
    accept_read  = cmd_read & ~reset & ~cmd_write & ~rd_hit;
    conflict     = ~reset & ((cmd_write & wr_hit) | (cmd_read & (cmd_write | rd_hit)));
    for (int i = 0; i < DEPTH - 1; i++) begin
      ins_write[i] = accept_write & win_w[i+1];
      ins_read[i]  = accept_read & win_r[i+1];
      ins_last[i]  = (accept_write && (i + 1 == WL + BC - 1)) ||
                     (accept_read && (i + 1 == CL + BC - 1));
    end
  end

  jelly_ddr_sdram_slot_shift #(
    .DEPTH (DEPTH)
  ) u_slot_shift (
    .clk       (clk),
    .reset     (reset),
    .ins_write (ins_write),
    .ins_read  (ins_read),
    .ins_last  (ins_last),
    .occ_write (occ_write),
    .occ_read  (occ_read),
    .head_last (head_last)
  );

  // A beat is requested one cycle before its bus slot and launched from a register.
  assign s_wready          = occ_write[1] | ins_write[0];
  assign dqs_write_next_en = occ_write[0] | s_wready;

  logic dq_en_q, err_underrun_q, err_conflict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dq_en_q        <= 1'b0;
      dq_write_even  <= '0;
      dq_write_odd   <= '0;
      dm_write_even  <= '0;
      dm_write_odd   <= '0;
      m_rdata_even   <= '0;
      m_rdata_odd    <= '0;
      err_underrun_q <= 1'b0;
      err_conflict_q <= 1'b0;
    end else begin
      dq_en_q      <= s_wready;
      m_rdata_even <= dq_read_even;
      m_rdata_odd  <= dq_read_odd;
      if (s_wready) begin
        dq_write_even <= s_wdata_even;
        dq_write_odd  <= s_wdata_odd;
        dm_write_even <= s_wvalid ? s_wmask_even : '1;
        dm_write_odd  <= s_wvalid ? s_wmask_odd : '1;
      end
      err_underrun_q <= err_underrun_q | (s_wready & ~s_wvalid);
      err_conflict_q <= err_conflict_q | conflict;
    end
  end

  assign dq_write_next_en = dq_en_q;
  assign err_underrun     = err_underrun_q;
  assign err_conflict     = err_conflict_q;

  // Read valid/last follow the slot head through the IO capture pipeline.
  logic [RCD:0] rv_pipe, rl_pipe;
  assign rv_pipe[0] = occ_read[0];
  assign rl_pipe[0] = occ_read[0] & head_last;

  for (genvar g = 0; g < RCD; g++) begin : g_rd_pipe
    always_ff @(posedge clk) begin
      if (reset) begin
        rv_pipe[g+1] <= 1'b0;
        rl_pipe[g+1] <= 1'b0;
      end else begin
        rv_pipe[g+1] <= rv_pipe[g];
        rl_pipe[g+1] <= rl_pipe[g];
      end
    end
  end

  assign m_rvalid = rv_pipe[RCD];
  assign m_rlast  = rl_pipe[RCD];
  assign busy     = (|occ_any) | (|rv_pipe) | (|rl_pipe) | dq_en_q;

`ifdef JELLY_DDR_SDRAM_DQ_SCHED_STAT_EN
  logic [15:0] stat_write_q, stat_read_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_write_q <= '0;
      stat_read_q  <= '0;
    end else begin
      if (accept_write && (stat_write_q != 16'hFFFF)) stat_write_q <= stat_write_q + 16'd1;
      if (accept_read && (stat_read_q != 16'hFFFF))   stat_read_q  <= stat_read_q + 16'd1;
    end
  end

  assign stat_write_bursts = stat_write_q;
  assign stat_read_bursts  = stat_read_q;
`else
  assign stat_write_bursts = '0;
  assign stat_read_bursts  = '0;
`endif

endmodule

// File: tb/tb_jelly_ddr_sdram_dq_sched.sv
// Directed bench for jelly_ddr_sdram_dq_sched at default parameters.
module tb_jelly_ddr_sdram_dq_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_write = 1'b0, cmd_read = 1'b0;
  logic [15:0] s_wdata_even = '0, s_wdata_odd = '0;
  logic [1:0]  s_wmask_even = '0, s_wmask_odd = '0;
  logic        s_wvalid = 1'b0, s_wready;
  logic [15:0] m_rdata_even, m_rdata_odd;
  logic        m_rvalid, m_rlast;
  logic        dq_write_next_en, dqs_write_next_en;
  logic [15:0] dq_write_even, dq_write_odd;
  logic [1:0]  dm_write_even, dm_write_odd;
  logic [15:0] dq_read_even = '0, dq_read_odd = '0;
  logic        busy, err_underrun, err_conflict;
  logic [15:0] stat_write_bursts, stat_read_bursts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jelly_ddr_sdram_dq_sched dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_write         (cmd_write),
    .cmd_read          (cmd_read),
    .s_wdata_even      (s_wdata_even),
    .s_wdata_odd       (s_wdata_odd),
    .s_wmask_even      (s_wmask_even),
    .s_wmask_odd       (s_wmask_odd),
    .s_wvalid          (s_wvalid),
    .s_wready          (s_wready),
    .m_rdata_even      (m_rdata_even),
    .m_rdata_odd       (m_rdata_odd),
    .m_rvalid          (m_rvalid),
    .m_rlast           (m_rlast),
    .dq_write_next_en  (dq_write_next_en),
    .dqs_write_next_en (dqs_write_next_en),
    .dq_write_even     (dq_write_even),
    .dq_write_odd      (dq_write_odd),
    .dm_write_even     (dm_write_even),
    .dm_write_odd      (dm_write_odd),
    .dq_read_even      (dq_read_even),
    .dq_read_odd       (dq_read_odd),
    .busy              (busy),
    .err_underrun      (err_underrun),
    .err_conflict      (err_conflict),
    .stat_write_bursts (stat_write_bursts),
    .stat_read_bursts  (stat_read_bursts)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_write = 1'b0;
    cmd_read  = 1'b0;
    s_wvalid  = 1'b0;
    s_wdata_even = '0;
    s_wdata_odd  = '0;
    s_wmask_even = '0;
    s_wmask_odd  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    idle_inputs();
    reset = 1'b1;
    repeat (3) next_cycle();
    reset = 1'b0;
    @(negedge clk);
    got = {s_wready, dqs_write_next_en, dq_write_next_en, m_rvalid, m_rlast, busy,
           err_underrun, err_conflict};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags got %b expected 00000000", got);
    end
    checks++;
    if ({dq_write_even, dq_write_odd, dm_write_even, dm_write_odd, m_rdata_even, m_rdata_odd}
        !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h %b/%b %h/%h expected all zero", dq_write_even,
               dq_write_odd, dm_write_even, dm_write_odd, m_rdata_even, m_rdata_odd);
    end
    checks++;
    if ({stat_write_bursts, stat_read_bursts} !== 32'h0) begin
      errors++;
      $display("FAIL reset_stats got %h/%h expected 0/0", stat_write_bursts, stat_read_bursts);
    end
    next_cycle();
  endtask

  task automatic test_write();
    logic [2:0]  exp_en;
    logic [31:0] exp_dq;
    for (int k = 0; k < 5; k++) begin
      cmd_write    = (k == 0);
      s_wvalid     = 1'b1;
      s_wdata_even = (k == 0) ? 16'h1111 : (k == 1) ? 16'h3333 : 16'h0000;
      s_wdata_odd  = (k == 0) ? 16'h2222 : (k == 1) ? 16'h4444 : 16'h0000;
      @(negedge clk);
      exp_en = {k <= 1, k <= 2, (k == 1) || (k == 2)};
      checks++;
      if ({s_wready, dqs_write_next_en, dq_write_next_en} !== exp_en) begin
        errors++;
        $display("FAIL write_enables k=%0d got %b expected %b", k,
                 {s_wready, dqs_write_next_en, dq_write_next_en}, exp_en);
      end
      if ((k == 1) || (k == 2)) begin
        exp_dq = (k == 1) ? 32'h1111_2222 : 32'h3333_4444;
        checks++;
        if ({dq_write_even, dq_write_odd, dm_write_even, dm_write_odd} !== {exp_dq, 4'b0000}) begin
          errors++;
          $display("FAIL write_data k=%0d got %h/%h dm %b/%b expected %h dm 00/00", k,
                   dq_write_even, dq_write_odd, dm_write_even, dm_write_odd, exp_dq);
        end
      end
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL write_busy got %b expected 1", busy);
        end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({busy, err_underrun, err_conflict} !== 3'b000) begin
      errors++;
      $display("FAIL write_drain got busy/und/conf %b expected 000",
               {busy, err_underrun, err_conflict});
    end
    next_cycle();
  endtask

  task automatic test_read();
    logic [1:0]  exp_v;
    logic [31:0] exp_d;
    for (int k = 0; k < 7; k++) begin
      cmd_read     = (k == 0);
      dq_read_even = (k == 2) ? 16'hA5A5 : (k == 3) ? 16'hC3C3 : 16'hDEAD;
      dq_read_odd  = (k == 2) ? 16'h5A5A : (k == 3) ? 16'h3C3C : 16'hBEEF;
      @(negedge clk);
      exp_v = {(k == 3) || (k == 4), k == 4};
      checks++;
      if ({m_rvalid, m_rlast} !== exp_v) begin
        errors++;
        $display("FAIL read_valid k=%0d got %b expected %b", k, {m_rvalid, m_rlast}, exp_v);
      end
      if ((k == 3) || (k == 4)) begin
        exp_d = (k == 3) ? 32'hA5A5_5A5A : 32'hC3C3_3C3C;
        checks++;
        if ({m_rdata_even, m_rdata_odd} !== exp_d) begin
          errors++;
          $display("FAIL read_data k=%0d got %h/%h expected %h", k, m_rdata_even, m_rdata_odd,
                   exp_d);
        end
      end
      if (k == 1) begin
        checks++;
        if ({s_wready, dqs_write_next_en, dq_write_next_en} !== 3'b000) begin
          errors++;
          $display("FAIL read_no_write got %b expected 000",
                   {s_wready, dqs_write_next_en, dq_write_next_en});
        end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({busy, err_underrun, err_conflict} !== 3'b000) begin
      errors++;
      $display("FAIL read_drain got busy/und/conf %b expected 000",
               {busy, err_underrun, err_conflict});
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  exp_en;
    logic [1:0]  exp_v;
    logic [35:0] exp_w;
    for (int k = 0; k < 7; k++) begin
      cmd_write    = (k == 0) || (k == 2);
      s_wvalid     = 1'b1;
      s_wdata_even = 16'h1000 + 16'(k);
      s_wdata_odd  = 16'h2000 + 16'(k);
      s_wmask_even = (k == 2) ? 2'b01 : 2'b00;
      s_wmask_odd  = (k == 2) ? 2'b10 : 2'b00;
      @(negedge clk);
      exp_en = {k <= 3, k <= 4, (k >= 1) && (k <= 4)};
      checks++;
      if ({s_wready, dqs_write_next_en, dq_write_next_en} !== exp_en) begin
        errors++;
        $display("FAIL b2b_write_enables k=%0d got %b expected %b", k,
                 {s_wready, dqs_write_next_en, dq_write_next_en}, exp_en);
      end
      if ((k >= 1) && (k <= 4)) begin
        exp_w = {16'h1000 + 16'(k - 1), 16'h2000 + 16'(k - 1), (k == 3) ? 4'b0110 : 4'b0000};
        checks++;
        if ({dq_write_even, dq_write_odd, dm_write_even, dm_write_odd} !== exp_w) begin
          errors++;
          $display("FAIL b2b_write_data k=%0d got %h/%h dm %b/%b expected %h", k, dq_write_even,
                   dq_write_odd, dm_write_even, dm_write_odd, exp_w);
        end
      end
      next_cycle();
    end
    idle_inputs();
    for (int k = 0; k < 8; k++) begin
      cmd_read     = (k == 0) || (k == 2);
      dq_read_even = 16'hB000 + 16'(k);
      dq_read_odd  = 16'hC000 + 16'(k);
      @(negedge clk);
      exp_v = {(k >= 3) && (k <= 6), (k == 4) || (k == 6)};
      checks++;
      if ({m_rvalid, m_rlast} !== exp_v) begin
        errors++;
        $display("FAIL b2b_read_valid k=%0d got %b expected %b", k, {m_rvalid, m_rlast}, exp_v);
      end
      if ((k >= 3) && (k <= 6)) begin
        checks++;
        if ({m_rdata_even, m_rdata_odd} !== {16'hB000 + 16'(k - 1), 16'hC000 + 16'(k - 1)}) begin
          errors++;
          $display("FAIL b2b_read_data k=%0d got %h/%h expected %h/%h", k, m_rdata_even,
                   m_rdata_odd, 16'hB000 + 16'(k - 1), 16'hC000 + 16'(k - 1));
        end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({busy, err_conflict} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_no_conflict got busy/conf %b expected 00", {busy, err_conflict});
    end
    next_cycle();
  endtask

  task automatic test_conflict();
    logic [1:0] exp_v;
    for (int k = 0; k < 7; k++) begin
      cmd_read     = (k == 0);
      cmd_write    = (k == 1);
      s_wvalid     = 1'b1;
      dq_read_even = 16'h1230 + 16'(k);
      dq_read_odd  = 16'h4560 + 16'(k);
      @(negedge clk);
      checks++;
      if ({s_wready, dqs_write_next_en, dq_write_next_en} !== 3'b000) begin
        errors++;
        $display("FAIL conflict_no_write k=%0d got %b expected 000", k,
                 {s_wready, dqs_write_next_en, dq_write_next_en});
      end
      if (k >= 1) begin
        checks++;
        if (err_conflict !== (k >= 2)) begin
          errors++;
          $display("FAIL conflict_flag k=%0d got %b expected %b", k, err_conflict, k >= 2);
        end
      end
      exp_v = {(k == 3) || (k == 4), k == 4};
      checks++;
      if ({m_rvalid, m_rlast} !== exp_v) begin
        errors++;
        $display("FAIL conflict_read k=%0d got %b expected %b", k, {m_rvalid, m_rlast}, exp_v);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_underrun();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      cmd_write    = (k == 0);
      s_wvalid     = (k != 1);
      s_wdata_even = (k == 0) ? 16'h5555 : 16'h7777;
      s_wdata_odd  = (k == 0) ? 16'h6666 : 16'h8888;
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if ({dq_write_next_en, dq_write_even, dq_write_odd, dm_write_even, dm_write_odd,
             err_underrun} !== {1'b1, 16'h5555, 16'h6666, 4'b0000, 1'b0}) begin
          errors++;
          $display("FAIL underrun_first en=%b dq=%h/%h dm=%b/%b und=%b expected 1 5555/6666 00/00 0",
                   dq_write_next_en, dq_write_even, dq_write_odd, dm_write_even, dm_write_odd,
                   err_underrun);
        end
      end
      if ((k == 2) || (k == 3)) begin
        checks++;
        if ({dq_write_next_en, dm_write_even, dm_write_odd, err_underrun} !==
            {k == 2, 4'b1111, 1'b1}) begin
          errors++;
          $display("FAIL underrun_beat k=%0d en=%b dm=%b/%b und=%b expected %b 11/11 1", k,
                   dq_write_next_en, dm_write_even, dm_write_odd, err_underrun, k == 2);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 7; k++) begin
      cmd_write = (k == 0);
      cmd_read  = (k == 0);
      s_wvalid  = 1'b1;
      @(negedge clk);
      checks++;
      if ({s_wready, dq_write_next_en, m_rvalid} !== {k <= 1, (k == 1) || (k == 2), 1'b0}) begin
        errors++;
        $display("FAIL same_cycle k=%0d got wready/dqen/rvalid %b expected %b", k,
                 {s_wready, dq_write_next_en, m_rvalid}, {k <= 1, (k == 1) || (k == 2), 1'b0});
      end
      if (k == 1) begin
        checks++;
        if (err_conflict !== 1'b1) begin
          errors++;
          $display("FAIL same_cycle_flag got %b expected 1", err_conflict);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] exp_v;
    for (int k = 0; k < 11; k++) begin
      cmd_write    = (k == 0);
      cmd_read     = (k == 5);
      reset        = (k == 1);
      s_wvalid     = 1'b1;
      dq_read_even = (k == 7) ? 16'hA5A5 : (k == 8) ? 16'hC3C3 : 16'hDEAD;
      dq_read_odd  = (k == 7) ? 16'h5A5A : (k == 8) ? 16'h3C3C : 16'hBEEF;
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if ({err_underrun, err_conflict} !== 2'b11) begin
          errors++;
          $display("FAIL rst_flags_before got %b expected 11", {err_underrun, err_conflict});
        end
      end
      if ((k == 2) || (k == 3)) begin
        checks++;
        if ({s_wready, dqs_write_next_en, dq_write_next_en, busy, err_underrun, err_conflict}
            !== 6'b000000) begin
          errors++;
          $display("FAIL rst_abandon k=%0d got %b expected 000000", k,
                   {s_wready, dqs_write_next_en, dq_write_next_en, busy, err_underrun,
                    err_conflict});
        end
      end
      if (k >= 2) begin
        exp_v = {(k == 8) || (k == 9), k == 9};
        checks++;
        if ({m_rvalid, m_rlast} !== exp_v) begin
          errors++;
          $display("FAIL rst_read_valid k=%0d got %b expected %b", k, {m_rvalid, m_rlast}, exp_v);
        end
      end
      if ((k == 8) || (k == 9)) begin
        checks++;
        if ({m_rdata_even, m_rdata_odd} !== ((k == 8) ? 32'hA5A5_5A5A : 32'hC3C3_3C3C)) begin
          errors++;
          $display("FAIL rst_read_data k=%0d got %h/%h", k, m_rdata_even, m_rdata_odd);
        end
      end
      next_cycle();
    end
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_stats();
    logic [31:0] exp_s;
`ifdef JELLY_DDR_SDRAM_DQ_SCHED_STAT_EN
    exp_s = {16'd0, 16'd1};
`else
    exp_s = 32'h0;
`endif
    @(negedge clk);
    checks++;
    if ({stat_write_bursts, stat_read_bursts} !== exp_s) begin
      errors++;
      $display("FAIL stats got %h/%h expected %h", stat_write_bursts, stat_read_bursts, exp_s);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_conflict();
    test_underrun();
    test_same_cycle();
    test_reset_mid_burst();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
